// File: rtl/pmod_da4_spi_tx.sv
// SPI transmitter for the Pmod DA4 (AD5628): one reference-setup frame after reset,
// then a channel A / channel B frame pair for every accepted dac_start.
module pmod_da4_spi_tx #(
    parameter int HALF_PERIOD = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [11:0] dout1,
    input  logic [11:0] dout2,
    input  logic        dac_start,
    output logic        sclk,
    output logic        sync_n,
    output logic        din,
    output logic        busy,
    output logic        done,
    output logic        overrun
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_LOAD  = 2'd1;
    localparam logic [1:0] S_SHIFT = 2'd2;
    localparam logic [1:0] S_GAP   = 2'd3;

    localparam logic [1:0] W_REF = 2'd0;
    localparam logic [1:0] W_A   = 2'd1;
    localparam logic [1:0] W_B   = 2'd2;

    localparam logic [7:0] HP_LAST = 8'(HALF_PERIOD - 1);

    function automatic logic [31:0] word_for(input logic [1:0] sel,
                                             input logic [11:0] a,
                                             input logic [11:0] b);
        logic [31:0] w;
        case (sel)
            W_A:     w = {4'b0000, 4'b0011, 4'b0000, a, 8'h00};
            W_B:     w = {4'b0000, 4'b0011, 4'b0001, b, 8'h00};
            default: w = 32'h0800_0001;
        endcase
        return w;
    endfunction

    logic [1:0]  state_q, state_d;
    logic [1:0]  word_sel_q, word_sel_d;
    logic        init_pending_q, init_pending_d;
    logic [11:0] lat1_q, lat1_d;
    logic [11:0] lat2_q, lat2_d;
    logic [30:0] shreg_q, shreg_d;
    logic [4:0]  bit_cnt_q, bit_cnt_d;
    logic [7:0]  hp_cnt_q, hp_cnt_d;
    logic        sclk_q, sclk_d;
    logic        sync_n_q, sync_n_d;
    logic        din_q, din_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic        overrun_q, overrun_d;

    logic        start_frame;
    logic [1:0]  frame_sel;
    logic [31:0] frame_word;
    logic        tick;

    always_comb begin
        state_d        = state_q;
        word_sel_d     = word_sel_q;
        init_pending_d = init_pending_q;
        lat1_d         = lat1_q;
        lat2_d         = lat2_q;
        shreg_d        = shreg_q;
        bit_cnt_d      = bit_cnt_q;
        hp_cnt_d       = hp_cnt_q;
        sclk_d         = sclk_q;
        sync_n_d       = sync_n_q;
        din_d          = din_q;
        done_d         = 1'b0;
        overrun_d      = dac_start & busy_q;
        start_frame    = 1'b0;
        frame_sel      = W_REF;
        frame_word     = 32'h0;
        tick           = (hp_cnt_q == HP_LAST);

        case (state_q)
            S_IDLE: begin
                if (init_pending_q) begin
                    init_pending_d = 1'b0;
                    start_frame    = 1'b1;
                    frame_sel      = W_REF;
                end else if (dac_start) begin
                    lat1_d      = dout1;
                    lat2_d      = dout2;
                    start_frame = 1'b1;
                    frame_sel   = W_A;
                end
            end
            S_LOAD, S_SHIFT: begin
                state_d = S_SHIFT;
                if (tick) begin
                    hp_cnt_d = 8'd0;
                    if (sclk_q) begin
                        sclk_d = 1'b0;
                    end else if (bit_cnt_q == 5'd31) begin
                        // frame ends on the rising edge after the 32nd falling edge
                        sclk_d    = 1'b1;
                        sync_n_d  = 1'b1;
                        din_d     = 1'b0;
                        bit_cnt_d = 5'd0;
                        state_d   = S_GAP;
                    end else begin
                        sclk_d    = 1'b1;
                        din_d     = shreg_q[30];
                        shreg_d   = {shreg_q[29:0], 1'b0};
                        bit_cnt_d = bit_cnt_q + 5'd1;
                    end
                end else begin
                    hp_cnt_d = hp_cnt_q + 8'd1;
                end
            end
            default: begin
                // the gap spans two half-periods; bit_cnt[0] marks the second one
                if (tick) begin
                    hp_cnt_d = 8'd0;
                    if (bit_cnt_q[0]) begin
                        if (word_sel_q == W_A) begin
                            start_frame = 1'b1;
                            frame_sel   = W_B;
                        end else begin
                            state_d = S_IDLE;
                            done_d  = (word_sel_q == W_B);
                        end
                    end else begin
                        bit_cnt_d = 5'd1;
                    end
                end else begin
                    hp_cnt_d = hp_cnt_q + 8'd1;
                end
            end
        endcase

        if (start_frame) begin
            frame_word = word_for(frame_sel, lat1_d, lat2_d);
            state_d    = S_LOAD;
            word_sel_d = frame_sel;
            shreg_d    = frame_word[30:0];
            din_d      = frame_word[31];
            sync_n_d   = 1'b0;
            sclk_d     = 1'b1;
            bit_cnt_d  = 5'd0;
            hp_cnt_d   = 8'd0;
        end

        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= S_IDLE;
            word_sel_q     <= W_REF;
            init_pending_q <= 1'b1;
            lat1_q         <= 12'h0;
            lat2_q         <= 12'h0;
            shreg_q        <= 31'h0;
            bit_cnt_q      <= 5'd0;
            hp_cnt_q       <= 8'd0;
            sclk_q         <= 1'b1;
            sync_n_q       <= 1'b1;
            din_q          <= 1'b0;
            busy_q         <= 1'b1;
            done_q         <= 1'b0;
            overrun_q      <= 1'b0;
        end else begin
            state_q        <= state_d;
            word_sel_q     <= word_sel_d;
            init_pending_q <= init_pending_d;
            lat1_q         <= lat1_d;
            lat2_q         <= lat2_d;
            shreg_q        <= shreg_d;
            bit_cnt_q      <= bit_cnt_d;
            hp_cnt_q       <= hp_cnt_d;
            sclk_q         <= sclk_d;
            sync_n_q       <= sync_n_d;
            din_q          <= din_d;
            busy_q         <= busy_d;
            done_q         <= done_d;
            overrun_q      <= overrun_d;
        end
    end

    assign sclk    = sclk_q;
    assign sync_n  = sync_n_q;
    assign din     = din_q;
    assign busy    = busy_q;
    assign done    = done_q;
    assign overrun = overrun_q;

endmodule

// File: tb/tb_pmod_da4_spi_tx.sv
// Bench for pmod_da4_spi_tx: instance 0 runs HALF_PERIOD=1, instance 1 HALF_PERIOD=3;
// a negedge monitor decodes frames on falling sclk edges and records timing.
module tb_pmod_da4_spi_tx;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [11:0] d1_a    [2];
    logic [11:0] d2_a    [2];
    logic        start_a [2];
    logic        sclk_a  [2];
    logic        sync_a  [2];
    logic        din_a   [2];
    logic        busy_a  [2];
    logic        done_a  [2];
    logic        ovr_a   [2];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_dut
            pmod_da4_spi_tx #(.HALF_PERIOD(gi == 0 ? 1 : 3)) u_dut (
                .clk      (clk),
                .rst      (rst),
                .dout1    (d1_a[gi]),
                .dout2    (d2_a[gi]),
                .dac_start(start_a[gi]),
                .sclk     (sclk_a[gi]),
                .sync_n   (sync_a[gi]),
                .din      (din_a[gi]),
                .busy     (busy_a[gi]),
                .done     (done_a[gi]),
                .overrun  (ovr_a[gi])
            );
        end
    endgenerate

    // monitor state
    logic        prev_sclk [2];
    logic        prev_sync [2];
    logic        prev_din  [2];
    logic [31:0] cur_word  [2];
    int cur_bits [2], cur_low [2], cur_first [2], last_fall [2];
    int pmin [2], pmax [2], hi_cnt [2], cur_gap [2];
    int frm_cnt [2], done_cnt [2], ovr_cnt [2], viol [2];
    logic [31:0] frm_word [2][16];
    int frm_low [2][16], frm_bits [2][16], frm_gap [2][16];
    int frm_pmin [2][16], frm_pmax [2][16], frm_first [2][16];

    initial begin
        for (int ch = 0; ch < 2; ch++) begin
            frm_cnt[ch] = 0; done_cnt[ch] = 0; ovr_cnt[ch] = 0; viol[ch] = 0;
            d1_a[ch] = 12'h0; d2_a[ch] = 12'h0; start_a[ch] = 1'b0;
        end
    end

    always @(negedge clk) begin
        for (int ch = 0; ch < 2; ch++) begin
            if (rst) begin
                cur_bits[ch]  <= 0;
                cur_low[ch]   <= 0;
                cur_word[ch]  <= 32'h0;
                hi_cnt[ch]    <= 0;
                prev_sync[ch] <= 1'b1;
                prev_sclk[ch] <= 1'b1;
                prev_din[ch]  <= 1'b0;
            end else begin
                if (done_a[ch]) done_cnt[ch] <= done_cnt[ch] + 1;
                if (ovr_a[ch])  ovr_cnt[ch]  <= ovr_cnt[ch] + 1;
                if (!sync_a[ch]) begin
                    if (prev_sync[ch]) begin
                        cur_gap[ch]  <= hi_cnt[ch];
                        cur_bits[ch] <= 0;
                        cur_low[ch]  <= 1;
                        pmin[ch]     <= 99999;
                        pmax[ch]     <= 0;
                    end else begin
                        cur_low[ch] <= cur_low[ch] + 1;
                        if (din_a[ch] != prev_din[ch] && !(!prev_sclk[ch] && sclk_a[ch]))
                            viol[ch] <= viol[ch] + 1;
                        if (prev_sclk[ch] && !sclk_a[ch]) begin
                            if (cur_bits[ch] == 0) begin
                                cur_first[ch] <= cur_low[ch];
                            end else begin
                                if (cur_low[ch] - last_fall[ch] < pmin[ch]) pmin[ch] <= cur_low[ch] - last_fall[ch];
                                if (cur_low[ch] - last_fall[ch] > pmax[ch]) pmax[ch] <= cur_low[ch] - last_fall[ch];
                            end
                            last_fall[ch] <= cur_low[ch];
                            cur_word[ch]  <= {cur_word[ch][30:0], din_a[ch]};
                            cur_bits[ch]  <= cur_bits[ch] + 1;
                        end
                    end
                end else if (!prev_sync[ch]) begin
                    if (frm_cnt[ch] < 16) begin
                        frm_word[ch][frm_cnt[ch]]  <= cur_word[ch];
                        frm_low[ch][frm_cnt[ch]]   <= cur_low[ch];
                        frm_bits[ch][frm_cnt[ch]]  <= cur_bits[ch];
                        frm_gap[ch][frm_cnt[ch]]   <= cur_gap[ch];
                        frm_pmin[ch][frm_cnt[ch]]  <= pmin[ch];
                        frm_pmax[ch][frm_cnt[ch]]  <= pmax[ch];
                        frm_first[ch][frm_cnt[ch]] <= cur_first[ch];
                    end
                    frm_cnt[ch] <= frm_cnt[ch] + 1;
                    hi_cnt[ch]  <= 1;
                end else begin
                    hi_cnt[ch] <= hi_cnt[ch] + 1;
                end
                prev_sync[ch] <= sync_a[ch];
                prev_sclk[ch] <= sclk_a[ch];
                prev_din[ch]  <= din_a[ch];
            end
        end
    end

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_idle(input int ch, input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (!busy_a[ch]) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset;
        bit ok;
        int s [2];
        int dc [2];
        rst = 1'b1;
        start_a[0] = 1'b1;
        start_a[1] = 1'b1;
        cyc(4);
        @(negedge clk);
        for (int ch = 0; ch < 2; ch++) begin
            checks++;
            if ({sclk_a[ch], sync_a[ch], din_a[ch], busy_a[ch], done_a[ch], ovr_a[ch]} !== 6'b110100) begin
                errors++;
                $display("FAIL reset_state ch%0d: got %b want 110100", ch,
                         {sclk_a[ch], sync_a[ch], din_a[ch], busy_a[ch], done_a[ch], ovr_a[ch]});
            end
            s[ch] = frm_cnt[ch];
            dc[ch] = done_cnt[ch];
        end
        start_a[0] = 1'b0;
        start_a[1] = 1'b0;
        cyc(1);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        for (int ch = 0; ch < 2; ch++) begin
            checks++;
            if (sync_a[ch] !== 1'b0) begin
                errors++;
                $display("FAIL init_start ch%0d: sync_n=%b want 0", ch, sync_a[ch]);
            end
        end
        for (int ch = 0; ch < 2; ch++) begin
            wait_idle(ch, 600, ok);
            checks++;
            if (!ok) begin
                errors++;
                $display("FAIL init_timeout ch%0d: busy stuck, want 0", ch);
            end
        end
        @(negedge clk);
        for (int ch = 0; ch < 2; ch++) begin
            checks++;
            if (frm_cnt[ch] !== s[ch] + 1 || frm_word[ch][s[ch]] !== 32'h0800_0001) begin
                errors++;
                $display("FAIL init_frame ch%0d: count=%0d word=%h want count=%0d word=08000001",
                         ch, frm_cnt[ch] - s[ch], frm_word[ch][s[ch]], 1);
            end
            checks++;
            if (frm_low[ch][s[ch]] !== (ch == 0 ? 64 : 192) || frm_bits[ch][s[ch]] !== 32) begin
                errors++;
                $display("FAIL init_timing ch%0d: low=%0d bits=%0d want low=%0d bits=32",
                         ch, frm_low[ch][s[ch]], frm_bits[ch][s[ch]], ch == 0 ? 64 : 192);
            end
            checks++;
            if (done_cnt[ch] !== dc[ch] || busy_a[ch] !== 1'b0) begin
                errors++;
                $display("FAIL init_done ch%0d: done pulses=%0d busy=%b want 0 and 0",
                         ch, done_cnt[ch] - dc[ch], busy_a[ch]);
            end
        end
        $display("test_reset: init frames ch0=%h ch1=%h", frm_word[0][s[0]], frm_word[1][s[1]]);
    endtask

    task automatic test_update;
        bit ok;
        int s, dc, oc;
        s = frm_cnt[0]; dc = done_cnt[0]; oc = ovr_cnt[0];
        cyc(1);
        d1_a[0] = 12'hABC; d2_a[0] = 12'h123; start_a[0] = 1'b1;
        @(negedge clk);
        checks++;
        if (busy_a[0] !== 1'b0) begin
            errors++;
            $display("FAIL update_busy_before: busy=%b want 0", busy_a[0]);
        end
        cyc(1);
        start_a[0] = 1'b0; d1_a[0] = 12'hFFF; d2_a[0] = 12'hFFF;
        @(negedge clk);
        checks++;
        if (busy_a[0] !== 1'b1 || sync_a[0] !== 1'b0) begin
            errors++;
            $display("FAIL update_accept: busy=%b sync_n=%b want 1 0", busy_a[0], sync_a[0]);
        end
        wait_idle(0, 400, ok);
        @(negedge clk);
        checks++;
        if (!ok || frm_cnt[0] !== s + 2) begin
            errors++;
            $display("FAIL update_count: frames=%0d idle=%0d want 2 1", frm_cnt[0] - s, ok);
        end
        checks++;
        if (frm_word[0][s] !== 32'h030A_BC00 || frm_word[0][s+1] !== 32'h0311_2300) begin
            errors++;
            $display("FAIL update_words: %h %h want 030abc00 03112300", frm_word[0][s], frm_word[0][s+1]);
        end
        checks++;
        if (frm_gap[0][s+1] !== 2 || frm_low[0][s] !== 64 || frm_low[0][s+1] !== 64) begin
            errors++;
            $display("FAIL update_timing: gap=%0d lowA=%0d lowB=%0d want 2 64 64",
                     frm_gap[0][s+1], frm_low[0][s], frm_low[0][s+1]);
        end
        checks++;
        if (done_cnt[0] !== dc + 1 || ovr_cnt[0] !== oc) begin
            errors++;
            $display("FAIL update_flags: done=%0d overrun=%0d want 1 0", done_cnt[0] - dc, ovr_cnt[0] - oc);
        end
        $display("test_update: frames %h %h", frm_word[0][s], frm_word[0][s+1]);
    endtask

    task automatic test_overrun;
        bit ok;
        int s, dc, oc;
        s = frm_cnt[0]; dc = done_cnt[0]; oc = ovr_cnt[0];
        cyc(1);
        d1_a[0] = 12'h5A5; d2_a[0] = 12'h3C3; start_a[0] = 1'b1;
        cyc(1);
        start_a[0] = 1'b0;
        cyc(20);
        d1_a[0] = 12'h777; d2_a[0] = 12'h777; start_a[0] = 1'b1;
        cyc(1);
        start_a[0] = 1'b0;
        @(negedge clk);
        checks++;
        if (ovr_a[0] !== 1'b1) begin
            errors++;
            $display("FAIL overrun_pulse: overrun=%b want 1", ovr_a[0]);
        end
        @(negedge clk);
        checks++;
        if (ovr_a[0] !== 1'b0) begin
            errors++;
            $display("FAIL overrun_width: overrun=%b want 0", ovr_a[0]);
        end
        wait_idle(0, 400, ok);
        cyc(30);
        @(negedge clk);
        checks++;
        if (!ok || frm_cnt[0] !== s + 2 || frm_word[0][s] !== 32'h0305_A500 || frm_word[0][s+1] !== 32'h0313_C300) begin
            errors++;
            $display("FAIL overrun_frames: count=%0d %h %h want 2 0305a500 0313c300",
                     frm_cnt[0] - s, frm_word[0][s], frm_word[0][s+1]);
        end
        checks++;
        if (done_cnt[0] !== dc + 1 || ovr_cnt[0] !== oc + 1 || busy_a[0] !== 1'b0) begin
            errors++;
            $display("FAIL overrun_flags: done=%0d overrun=%0d busy=%b want 1 1 0",
                     done_cnt[0] - dc, ovr_cnt[0] - oc, busy_a[0]);
        end
        $display("test_overrun: frames %h %h overruns %0d", frm_word[0][s], frm_word[0][s+1], ovr_cnt[0] - oc);
    endtask

    task automatic test_reset_mid;
        bit ok;
        bit hit;
        int s, dc;
        s = frm_cnt[0]; dc = done_cnt[0];
        cyc(1);
        d1_a[0] = 12'h111; d2_a[0] = 12'h222; start_a[0] = 1'b1;
        cyc(1);
        start_a[0] = 1'b0;
        hit = 1'b0;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (frm_cnt[0] == s + 1 && !sync_a[0] && cur_bits[0] == 10) begin
                hit = 1'b1;
                break;
            end
        end
        checks++;
        if (!hit) begin
            errors++;
            $display("FAIL midreset_reach: bit 10 of frame B not reached, bits=%0d", cur_bits[0]);
        end
        cyc(1);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if (sync_a[0] !== 1'b1 || sclk_a[0] !== 1'b1 || din_a[0] !== 1'b0) begin
            errors++;
            $display("FAIL midreset_abort: sync_n=%b sclk=%b din=%b want 1 1 0", sync_a[0], sclk_a[0], din_a[0]);
        end
        cyc(2);
        rst = 1'b0;
        wait_idle(0, 400, ok);
        wait_idle(1, 600, ok);
        @(negedge clk);
        checks++;
        if (frm_cnt[0] !== s + 2 || frm_word[0][s] !== 32'h0301_1100 || frm_word[0][s+1] !== 32'h0800_0001) begin
            errors++;
            $display("FAIL midreset_frames: count=%0d %h %h want 2 03011100 08000001",
                     frm_cnt[0] - s, frm_word[0][s], frm_word[0][s+1]);
        end
        checks++;
        if (done_cnt[0] !== dc) begin
            errors++;
            $display("FAIL midreset_done: done=%0d want 0", done_cnt[0] - dc);
        end
        $display("test_reset_mid: frames %h %h", frm_word[0][s], frm_word[0][s+1]);
    endtask

    task automatic test_hp3;
        bit ok;
        int s, dc;
        s = frm_cnt[1]; dc = done_cnt[1];
        cyc(1);
        d1_a[1] = 12'hFFF; d2_a[1] = 12'h000; start_a[1] = 1'b1;
        cyc(1);
        start_a[1] = 1'b0;
        wait_idle(1, 1000, ok);
        @(negedge clk);
        checks++;
        if (!ok || frm_cnt[1] !== s + 2 || frm_word[1][s] !== 32'h030F_FF00 || frm_word[1][s+1] !== 32'h0310_0000) begin
            errors++;
            $display("FAIL hp3_frames: count=%0d %h %h want 2 030fff00 03100000",
                     frm_cnt[1] - s, frm_word[1][s], frm_word[1][s+1]);
        end
        for (int k = 0; k < 2; k++) begin
            checks++;
            if (frm_low[1][s+k] !== 192 || frm_bits[1][s+k] !== 32 || frm_pmin[1][s+k] !== 6 ||
                frm_pmax[1][s+k] !== 6 || frm_first[1][s+k] !== 3) begin
                errors++;
                $display("FAIL hp3_timing frame%0d: low=%0d bits=%0d period=%0d..%0d first=%0d want 192 32 6..6 3",
                         k, frm_low[1][s+k], frm_bits[1][s+k], frm_pmin[1][s+k], frm_pmax[1][s+k], frm_first[1][s+k]);
            end
        end
        checks++;
        if (frm_gap[1][s+1] !== 6 || done_cnt[1] !== dc + 1) begin
            errors++;
            $display("FAIL hp3_gap_done: gap=%0d done=%0d want 6 1", frm_gap[1][s+1], done_cnt[1] - dc);
        end
        for (int ch = 0; ch < 2; ch++) begin
            checks++;
            if (viol[ch] !== 0) begin
                errors++;
                $display("FAIL din_stability ch%0d: %0d changes off the sclk rise, want 0", ch, viol[ch]);
            end
        end
        $display("test_hp3: frames %h %h", frm_word[1][s], frm_word[1][s+1]);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_update();
        test_overrun();
        test_reset_mid();
        test_hp3();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
